mouse_pos: RTL and testbench

MOUSE_POS -- requirements
Module: mouse_pos

---
 rtl/mouse_pkg.sv | 42 ++++
 rtl/ps2_pkt_asm.sv | 112 +++++++++++
 rtl/mouse_pos.sv | 100 ++++++++++
 tb/tb_mouse_pos.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mouse_pkg.sv
// Shared types and constants for the PS/2 mouse cursor path.
// Optional MOUSE_BTN_EN adds button fields to the packet bundle.
package mouse_pkg;

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } pkt_state_t;

  localparam int COL_CENTER  = 320;
  localparam int ROW_CENTER  = 240;
  localparam int COL_MIN_DEF = 192;
  localparam int COL_MAX_DEF = 448;
  localparam int ROW_MIN_DEF = 112;
  localparam int ROW_MAX_DEF = 368;
  localparam int TIMEOUT_DEF = 2000000;

  typedef struct packed {
    logic       ovf;
    logic       sy;
    logic       sx;
`ifdef MOUSE_BTN_EN
    logic [1:0] btn;
`endif
    logic [7:0] x;
    logic [7:0] y;
  } pkt_t;

  function automatic logic [10:0] clamp11(
    input logic signed [10:0] v,
    input int                 lo,
    input int                 hi
  );
    int vi;
    vi = int'(v);
    if (vi < lo) vi = lo;
    if (vi > hi) vi = hi;
    return 11'(vi);
  endfunction

endpackage

// File: rtl/ps2_pkt_asm.sv
// Assembles 3-byte PS/2 mouse packets with header resync and
// an inter-byte timeout that drops partial packets.
module ps2_pkt_asm
  import mouse_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       pkt_strobe,
  output pkt_t       pkt
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  pkt_state_t    state;
  pkt_state_t    state_nxt;
  logic [CW-1:0] gap_cnt;
  logic          timeout;
  logic          take_hdr;
  logic          ovf_q;
  logic          sy_q;
  logic          sx_q;
  logic [7:0]    x_q;
`ifdef MOUSE_BTN_EN
  logic [1:0]    btn_q;
`endif

  assign take_hdr = rx_valid && (state == WAIT_B0) && rx_data[3];

  assign timeout = (state != WAIT_B0) && !rx_valid &&
                   (gap_cnt == CW'(TIMEOUT_CYC - 1));

  // Next-state: consume only on rx_valid, abandon partials on timeout
  always_comb begin
    state_nxt  = state;
    pkt_strobe = 1'b0;
    unique case (state)
      WAIT_B0: begin
        if (take_hdr) state_nxt = WAIT_B1;
      end
      WAIT_B1: begin
        if (rx_valid)     state_nxt = WAIT_B2;
        else if (timeout) state_nxt = WAIT_B0;
      end
      WAIT_B2: begin
        if (rx_valid) begin
          state_nxt  = WAIT_B0;
          pkt_strobe = 1'b1;
        end else if (timeout) begin
          state_nxt = WAIT_B0;
        end
      end
      default: state_nxt = WAIT_B0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_B0;
    else        state <= state_nxt;
  end

  // Idle-cycle counter, only runs while a packet is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      gap_cnt <= '0;
    else if (rx_valid || state == WAIT_B0 || timeout)
      gap_cnt <= '0;
    else
      gap_cnt <= gap_cnt + 1'b1;
  end

  // Header fields and X byte capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      sy_q  <= 1'b0;
      sx_q  <= 1'b0;
      x_q   <= '0;
`ifdef MOUSE_BTN_EN
      btn_q <= '0;
`endif
    end else begin
      if (take_hdr) begin
        ovf_q <= rx_data[7] | rx_data[6];
        sy_q  <= rx_data[5];
        sx_q  <= rx_data[4];
`ifdef MOUSE_BTN_EN
        btn_q <= rx_data[1:0];
`endif
      end
      if (rx_valid && state == WAIT_B1) x_q <= rx_data;
    end
  end

  // Y byte goes straight through so the update lands next cycle
  always_comb begin
    pkt     = '0;
    pkt.ovf = ovf_q;
    pkt.sy  = sy_q;
    pkt.sx  = sx_q;
`ifdef MOUSE_BTN_EN
    pkt.btn = btn_q;
`endif
    pkt.x   = x_q;
    pkt.y   = rx_data;
  end

endmodule

// File: rtl/mouse_pos.sv
// Cursor position tracker: clamps PS/2 deltas into a window and
// publishes on vsync. MOUSE_BTN_EN adds btn_left/btn_right.
module mouse_pos
  import mouse_pkg::*;
#(
  parameter int COL_MIN     = COL_MIN_DEF,
  parameter int COL_MAX     = COL_MAX_DEF,
  parameter int ROW_MIN     = ROW_MIN_DEF,
  parameter int ROW_MAX     = ROW_MAX_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       vsync_tick,
`ifdef MOUSE_BTN_EN
  output logic       btn_left,
  output logic       btn_right,
`endif
  output logic [9:0] mouse_col,
  output logic [8:0] mouse_row,
  output logic       pkt_done
);

  logic               pkt_strobe;
  pkt_t               pkt;
  logic               accept;
  logic signed [10:0] dx;
  logic signed [10:0] dy;
  logic signed [10:0] col_sum;
  logic signed [10:0] row_sum;
  logic [10:0]        col_cl;
  logic [10:0]        row_cl;
  logic [9:0]         col_q;
  logic [8:0]         row_q;

  ps2_pkt_asm #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_asm (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .pkt_strobe(pkt_strobe),
    .pkt       (pkt)
  );

  assign accept = pkt_strobe && !pkt.ovf;

  // Sign-extended deltas and clamped candidate position
  always_comb begin
    dx      = {{3{pkt.sx}}, pkt.x};
    dy      = {{3{pkt.sy}}, pkt.y};
    col_sum = $signed({1'b0, col_q}) + dx;
    row_sum = $signed({2'b00, row_q}) - dy;
    col_cl  = clamp11(col_sum, COL_MIN, COL_MAX);
    row_cl  = clamp11(row_sum, ROW_MIN, ROW_MAX);
  end

  // Internal position and packet pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= 10'(COL_CENTER);
      row_q    <= 9'(ROW_CENTER);
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= accept;
      if (accept) begin
        col_q <= col_cl[9:0];
        row_q <= row_cl[8:0];
      end
    end
  end

  // Frame-synchronous publish of the internal position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mouse_col <= 10'(COL_CENTER);
      mouse_row <= 9'(ROW_CENTER);
    end else if (vsync_tick) begin
      mouse_col <= col_q;
      mouse_row <= row_q;
    end
  end

`ifdef MOUSE_BTN_EN
  // Buttons follow each accepted packet without frame sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_left  <= 1'b0;
      btn_right <= 1'b0;
    end else if (accept) begin
      btn_left  <= pkt.btn[0];
      btn_right <= pkt.btn[1];
    end
  end
`endif

endmodule

// File: tb/tb_mouse_pos.sv
// Directed bench for mouse_pos: packet decode, clamping, resync,
// timeout, overflow drop, vsync publishing and async reset.
module tb_mouse_pos;

  localparam int TO = 50;

  logic       clk;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       vsync_tick;
  logic [9:0] mouse_col;
  logic [8:0] mouse_row;
  logic       pkt_done;
`ifdef MOUSE_BTN_EN
  logic       btn_left;
  logic       btn_right;
`endif

  int n_cmp;
  int n_bad;
  int done_cnt;
  int d0;

  mouse_pos #(
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .vsync_tick(vsync_tick),
`ifdef MOUSE_BTN_EN
    .btn_left  (btn_left),
    .btn_right (btn_right),
`endif
    .mouse_col (mouse_col),
    .mouse_row (mouse_row),
    .pkt_done  (pkt_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (pkt_done === 1'b1) done_cnt++;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    rx_valid   = 1'b0;
    vsync_tick = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pkt3(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c);
    send(a);
    send(b);
    send(c);
  endtask

  task automatic tick();
    @(negedge clk);
    vsync_tick = 1'b1;
    @(negedge clk);
    vsync_tick = 1'b0;
  endtask

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    done_cnt   = 0;
    rst_n      = 1'b0;
    rx_data    = '0;
    rx_valid   = 1'b0;
    vsync_tick = 1'b0;

    do_reset();
    check("rst_col", int'(mouse_col), 320);
    check("rst_row", int'(mouse_row), 240);
    check("rst_done", int'(pkt_done), 0);

    // basic packet, held until vsync
    d0 = done_cnt;
    pkt3(8'h08, 8'h0A, 8'h05);
    check("basic_hold_col", int'(mouse_col), 320);
    tick();
    check("basic_col", int'(mouse_col), 330);
    check("basic_row", int'(mouse_row), 235);
    check("basic_done", done_cnt - d0, 1);

    // column lower clamp then +255
    do_reset();
    pkt3(8'h18, 8'h00, 8'h00);
    tick();
    check("colmin_col", int'(mouse_col), 192);
    check("colmin_row", int'(mouse_row), 240);
    pkt3(8'h08, 8'hFF, 8'h00);
    tick();
    check("dx255_col", int'(mouse_col), 447);

    // resync on byte without bit3
    do_reset();
    d0 = done_cnt;
    send(8'h00);
    pkt3(8'h08, 8'h01, 8'h01);
    tick();
    check("resync_col", int'(mouse_col), 321);
    check("resync_row", int'(mouse_row), 239);
    check("resync_done", done_cnt - d0, 1);

    // timeout discards partial packet
    do_reset();
    d0 = done_cnt;
    send(8'h08);
    send(8'h05);
    repeat (TO + 1) @(negedge clk);
    pkt3(8'h08, 8'h01, 8'h00);
    tick();
    check("timeout_col", int'(mouse_col), 321);
    check("timeout_row", int'(mouse_row), 240);
    check("timeout_done", done_cnt - d0, 1);

    // overflow packet dropped
    do_reset();
    d0 = done_cnt;
    pkt3(8'h48, 8'h7F, 8'h00);
    tick();
    check("ovf_col", int'(mouse_col), 320);
    check("ovf_done", done_cnt - d0, 0);

    // completing byte coincides with vsync
    do_reset();
    send(8'h08);
    send(8'h0A);
    @(negedge clk);
    rx_data    = 8'h05;
    rx_valid   = 1'b1;
    vsync_tick = 1'b1;
    @(negedge clk);
    rx_valid   = 1'b0;
    vsync_tick = 1'b0;
    check("same_col", int'(mouse_col), 320);
    check("same_row", int'(mouse_row), 240);
    tick();
    check("same_next_col", int'(mouse_col), 330);
    check("same_next_row", int'(mouse_row), 235);

    // accumulation between ticks
    do_reset();
    d0 = done_cnt;
    pkt3(8'h08, 8'h0A, 8'h05);
    pkt3(8'h08, 8'h0A, 8'h05);
    tick();
    check("accum_col", int'(mouse_col), 340);
    check("accum_row", int'(mouse_row), 230);
    check("accum_done", done_cnt - d0, 2);

    // row and column window edges
    do_reset();
    pkt3(8'h08, 8'h00, 8'h7F);
    pkt3(8'h08, 8'h00, 8'h7F);
    tick();
    check("rowmin_row", int'(mouse_row), 112);
    pkt3(8'h28, 8'h00, 8'h00);
    tick();
    check("rowmax_row", int'(mouse_row), 368);
    pkt3(8'h08, 8'h7F, 8'h00);
    pkt3(8'h08, 8'h7F, 8'h00);
    tick();
    check("colmax_col", int'(mouse_col), 448);

    // async reset mid-packet
    do_reset();
    pkt3(8'h08, 8'h0A, 8'h05);
    tick();
    check("pre_rst_col", int'(mouse_col), 330);
    send(8'h08);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_col", int'(mouse_col), 320);
    check("arst_row", int'(mouse_row), 240);
    check("arst_done", int'(pkt_done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    pkt3(8'h08, 8'h0A, 8'h05);
    tick();
    check("post_rst_col", int'(mouse_col), 330);
    check("post_rst_row", int'(mouse_row), 235);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
